ws2812_rx: RTL and testbench

- WS2812 one-wire receiver/decoder, the other end of ws2812_driver's NRZ output.
- Measures high-pulse widths on a single input, classifies each as a 0 or 1 bit, and assembles 24-bit pixel words, MSB first.
- Captures a full frame into a flat bus in the same layout that ws2812_driver consumes, so loopback benches and chained-strip emulation can compare frames directly.

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_bit_decoder.sv | 122 ++++++++++++
 rtl/ws2812_rx.sv | 133 +++++++++++++
 tb/tb_ws2812_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 receive path.
// Timing defaults assume a 100 MHz sampling clock.
package ws2812_pkg;

    localparam int DEF_BIT_THRESH_CYCLES = 60;
    localparam int DEF_MIN_HIGH_CYCLES   = 10;
    localparam int DEF_MAX_HIGH_CYCLES   = 150;
    localparam int DEF_RESET_CYCLES      = 5000;
    localparam int BITS_PER_PIXEL        = 24;

    typedef enum logic [1:0] {
        ERR_GLITCH   = 2'd0,
        ERR_STUCK    = 2'd1,
        ERR_PARTIAL  = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Synchronizes din, measures high/low widths and turns each high pulse into
// a bit, a glitch/stuck error, or (after a long low) a latch strobe.
module ws2812_bit_decoder
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH_CYCLES = DEF_BIT_THRESH_CYCLES,
    parameter int MIN_HIGH_CYCLES   = DEF_MIN_HIGH_CYCLES,
    parameter int MAX_HIGH_CYCLES   = DEF_MAX_HIGH_CYCLES,
    parameter int RESET_CYCLES      = DEF_RESET_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      din,
    output logic      bit_valid,
    output logic      bit_value,
    output logic      latch,
    output logic      bit_err,
    output err_code_t bit_err_code,
    output logic      busy,
    output rx_state_t state
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH_CYCLES);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH_CYCLES);

    logic             din_s1, din_s2, din_d;
    logic             rise, fall, gap_done, too_short, too_long;
    logic [CNT_W-1:0] high_cnt, low_cnt;
    rx_state_t        state_nxt;
    logic             bit_valid_nxt, bit_value_nxt, latch_nxt, bit_err_nxt, busy_nxt;
    err_code_t        bit_err_code_nxt;

    // Counters hold the number of previous consecutive high/low cycles,
    // so the current cycle is counted by comparing against limit-1.
    assign rise      = din_s2 & ~din_d;
    assign fall      = ~din_s2 & din_d;
    assign gap_done  = ~din_s2 && (low_cnt >= GAP_LAST);
    assign too_short = high_cnt < MIN_C;
    assign too_long  = din_s2 && (high_cnt >= MAX_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_s1       <= 1'b0;
            din_s2       <= 1'b0;
            din_d        <= 1'b0;
            high_cnt     <= '0;
            low_cnt      <= '0;
            state        <= ST_WAIT_GAP;
            bit_valid    <= 1'b0;
            bit_value    <= 1'b0;
            latch        <= 1'b0;
            bit_err      <= 1'b0;
            bit_err_code <= ERR_GLITCH;
            busy         <= 1'b0;
        end else begin
            din_s1       <= din;
            din_s2       <= din_s1;
            din_d        <= din_s2;
            high_cnt     <= din_s2 ? ((high_cnt == CNT_MAX) ? high_cnt : high_cnt + 1'b1) : '0;
            low_cnt      <= din_s2 ? '0 : ((low_cnt == CNT_MAX) ? low_cnt : low_cnt + 1'b1);
            state        <= state_nxt;
            bit_valid    <= bit_valid_nxt;
            bit_value    <= bit_value_nxt;
            latch        <= latch_nxt;
            bit_err      <= bit_err_nxt;
            bit_err_code <= bit_err_code_nxt;
            busy         <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_GAP: if (gap_done) state_nxt = ST_IDLE;
            ST_IDLE:     if (rise) state_nxt = ST_HIGH;
            ST_HIGH: begin
                if (fall)          state_nxt = too_short ? ST_WAIT_GAP : ST_LOW;
                else if (too_long) state_nxt = ST_WAIT_GAP;
            end
            ST_LOW: begin
                if (rise)          state_nxt = ST_HIGH;
                else if (gap_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_WAIT_GAP;
        endcase
    end

    always_comb begin
        bit_valid_nxt    = 1'b0;
        bit_value_nxt    = (high_cnt >= THRESH_C);
        latch_nxt        = 1'b0;
        bit_err_nxt      = 1'b0;
        bit_err_code_nxt = ERR_GLITCH;
        busy_nxt         = busy;
        case (state)
            ST_WAIT_GAP: if (gap_done) begin
                latch_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
            ST_IDLE: if (rise) busy_nxt = 1'b1;
            ST_HIGH: begin
                if (fall) begin
                    bit_err_nxt   = too_short;
                    bit_valid_nxt = ~too_short;
                end else if (too_long) begin
                    bit_err_nxt      = 1'b1;
                    bit_err_code_nxt = ERR_STUCK;
                end
            end
            ST_LOW: if (!rise && gap_done) begin
                latch_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: assembles decoded bits into 24-bit pixels, buffers a frame
// and publishes it on latch. All outputs are strobes; there is no backpressure.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int LED_COUNT         = 8,
    parameter int BIT_THRESH_CYCLES = DEF_BIT_THRESH_CYCLES,
    parameter int MIN_HIGH_CYCLES   = DEF_MIN_HIGH_CYCLES,
    parameter int MAX_HIGH_CYCLES   = DEF_MAX_HIGH_CYCLES,
    parameter int RESET_CYCLES      = DEF_RESET_CYCLES,
    localparam int IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1,
    localparam int PIX_W = $clog2(LED_COUNT + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din,
    output logic                          pixel_valid,
    output logic [BITS_PER_PIXEL-1:0]     pixel_data,
    output logic [IDX_W-1:0]              pixel_index,
    output logic                          frame_valid,
    output logic [LED_COUNT*BITS_PER_PIXEL-1:0] frame_data,
    output logic [PIX_W-1:0]              frame_pixels,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic                          busy,
    output rx_state_t                     dbg_state
);

    localparam logic [4:0]       LAST_BIT = 5'(BITS_PER_PIXEL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_COUNT - 1);

    logic                      bit_valid, bit_value, latch, bit_err;
    err_code_t                 bit_err_code;
    logic [4:0]                bit_count;
    logic [BITS_PER_PIXEL-2:0] word;
    logic [BITS_PER_PIXEL-1:0] full_word;
    logic [BITS_PER_PIXEL-1:0] shadow [LED_COUNT];
    logic [PIX_W-1:0]          pix_cnt;
    logic                      ovf_seen, aborted, room;

    assign full_word = {word, bit_value};
    assign room      = pix_cnt < PIX_W'(LED_COUNT);

    ws2812_bit_decoder #(
        .BIT_THRESH_CYCLES(BIT_THRESH_CYCLES),
        .MIN_HIGH_CYCLES  (MIN_HIGH_CYCLES),
        .MAX_HIGH_CYCLES  (MAX_HIGH_CYCLES),
        .RESET_CYCLES     (RESET_CYCLES)
    ) u_dec (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .bit_valid   (bit_valid),
        .bit_value   (bit_value),
        .latch       (latch),
        .bit_err     (bit_err),
        .bit_err_code(bit_err_code),
        .busy        (busy),
        .state       (dbg_state)
    );

    // An aborted frame is dropped silently at its latch; the shadow is
    // scrubbed there so the next frame starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_valid  <= 1'b0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            frame_valid  <= 1'b0;
            frame_data   <= '0;
            frame_pixels <= '0;
            err          <= 1'b0;
            err_code     <= '0;
            bit_count    <= '0;
            word         <= '0;
            pix_cnt      <= '0;
            ovf_seen     <= 1'b0;
            aborted      <= 1'b0;
            for (int k = 0; k < LED_COUNT; k++) shadow[k] <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (bit_err) begin
                err      <= 1'b1;
                err_code <= bit_err_code;
                aborted  <= 1'b1;
            end
            if (bit_valid && !aborted) begin
                if (bit_count == LAST_BIT) begin
                    pixel_valid <= 1'b1;
                    pixel_data  <= full_word;
                    bit_count   <= '0;
                    word        <= '0;
                    if (room) begin
                        shadow[pix_cnt[IDX_W-1:0]] <= full_word;
                        pixel_index <= pix_cnt[IDX_W-1:0];
                        pix_cnt     <= pix_cnt + 1'b1;
                    end else begin
                        pixel_index <= LAST_IDX;
                        if (!ovf_seen) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERFLOW;
                            ovf_seen <= 1'b1;
                        end
                    end
                end else begin
                    bit_count <= bit_count + 1'b1;
                    word      <= full_word[BITS_PER_PIXEL-2:0];
                end
            end
            if (latch) begin
                if (!aborted && bit_count != '0) begin
                    err      <= 1'b1;
                    err_code <= ERR_PARTIAL;
                end
                if (!aborted && pix_cnt != '0) begin
                    for (int k = 0; k < LED_COUNT; k++)
                        frame_data[k*BITS_PER_PIXEL +: BITS_PER_PIXEL] <= shadow[k];
                    frame_pixels <= pix_cnt;
                    frame_valid  <= 1'b1;
                end
                for (int k = 0; k < LED_COUNT; k++) shadow[k] <= '0;
                pix_cnt   <= '0;
                bit_count <= '0;
                word      <= '0;
                ovf_seen  <= 1'b0;
                aborted   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: pulse-level driver, pixel scoreboard and
// per-frame checks of frame/err/busy behaviour.
`timescale 1ns/1ps
module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int LEDS = 8;
    localparam int FW   = LEDS * 24;
    localparam int GAP  = 1000;

    logic            clk = 1'b0;
    logic            reset, din;
    logic            pixel_valid, frame_valid, err, busy;
    logic [23:0]     pixel_data;
    logic [2:0]      pixel_index;
    logic [FW-1:0]   frame_data;
    logic [3:0]      frame_pixels;
    logic [1:0]      err_code;
    rx_state_t       dbg_state;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, last_fall_cyc = 0, rise_cyc = 0, err_cyc = 0;
    int hi0, lo0, hi1, lo1;
    int fv_seen, err_seen, pv_extra;
    logic [1:0]    last_err;
    logic [3:0]    fv_pixels_last;
    logic [FW-1:0] fv_data_last, exp_frame;
    logic [23:0]   exp_q[$];
    logic [2:0]    exp_idx_q[$];
    logic [23:0]   ideal [8];
    logic [23:0]   w;

    ws2812_rx #(
        .LED_COUNT(LEDS), .BIT_THRESH_CYCLES(60), .MIN_HIGH_CYCLES(10),
        .MAX_HIGH_CYCLES(150), .RESET_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .din(din),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_index(pixel_index),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_pixels(frame_pixels),
        .err(err), .err_code(err_code), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every pixel strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (pixel_valid) begin
            if (exp_q.size() == 0) pv_extra++;
            else begin
                check("pv_data", pixel_data, exp_q.pop_front());
                check("pv_index", pixel_index, exp_idx_q.pop_front());
                check("pv_latency", cyc - last_fall_cyc, 4);
            end
        end
        if (frame_valid) begin
            fv_seen++;
            fv_pixels_last = frame_pixels;
            fv_data_last   = frame_data;
        end
        if (err) begin
            err_seen++;
            last_err = err_code;
            err_cyc  = cyc;
        end
    end

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        rise_cyc = cyc;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        last_fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] v, input int msb, input int n);
        for (int i = msb; i > msb - n; i--) begin
            if (v[i]) pulse(hi1, lo1);
            else      pulse(hi0, lo0);
        end
    endtask

    task automatic expect_pixel(input logic [23:0] v, input logic [2:0] idx);
        exp_q.push_back(v);
        exp_idx_q.push_back(idx);
    endtask

    task automatic new_phase();
        fv_seen = 0;
        err_seen = 0;
        pv_extra = 0;
    endtask

    task automatic gap_and_drain();
        repeat (GAP + 200) @(negedge clk);
        check("exp_left", exp_q.size(), 0);
        check("pv_extra", pv_extra, 0);
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        hi0 = 40; lo0 = 85; hi1 = 80; lo1 = 45;
        ideal = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                  24'h000000, 24'h000000, 24'h000000, 24'h000000};
        new_phase();
        repeat (5) @(negedge clk);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_data", pixel_data, 0);
        check("rst_pixel_index", pixel_index, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_frame_pixels", frame_pixels, 0);
        check("rst_err", {err, err_code}, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_WAIT_GAP);
        reset = 1'b0;
        repeat (GAP + 100) @(negedge clk);
        check("init_state", dbg_state, ST_IDLE);

        // Ideal 8-pixel frame with nominal timing
        new_phase();
        exp_frame = '0;
        for (int k = 0; k < 8; k++) begin
            expect_pixel(ideal[k], 3'(k));
            exp_frame[k*24 +: 24] = ideal[k];
            send_bits(ideal[k], 23, 24);
            if (k == 0) check("ideal_busy", busy, 1);
        end
        gap_and_drain();
        check("ideal_fv", fv_seen, 1);
        check("ideal_pixels", fv_pixels_last, 8);
        check("ideal_frame", fv_data_last, exp_frame);
        check("ideal_slot0", frame_data[23:0], 24'hFF0000);
        check("ideal_slot3", frame_data[95:72], 24'hFFFFFF);
        check("ideal_err", err_seen, 0);
        check("ideal_busy_done", busy, 0);

        // Threshold edges: 59 -> 0, 60 -> 1
        hi0 = 25; lo0 = 20; hi1 = 70; lo1 = 20;
        new_phase();
        w = {2'b01, 22'h2AAAAA};
        expect_pixel(w, 3'd0);
        pulse(59, 40);
        pulse(60, 40);
        send_bits(w, 21, 22);
        gap_and_drain();
        exp_frame = '0;
        exp_frame[23:0] = w;
        check("thr_fv", fv_seen, 1);
        check("thr_pixels", frame_pixels, 1);
        check("thr_frame", frame_data, exp_frame);

        // Stuck high
        new_phase();
        din = 1'b1;
        rise_cyc = cyc;
        repeat (200) @(negedge clk);
        check("stuck_err_cnt", err_seen, 1);
        check("stuck_code", err_code, ERR_STUCK);
        check("stuck_when", (err_cyc - rise_cyc >= 148) && (err_cyc - rise_cyc <= 158), 1);
        check("stuck_busy", busy, 1);
        din = 1'b0;
        gap_and_drain();
        check("stuck_fv", fv_seen, 0);
        check("stuck_busy_done", busy, 0);
        check("stuck_keep_frame", frame_data, exp_frame);

        // Glitch, then ignored traffic, then a fresh frame
        new_phase();
        send_bits(24'hFFFFFF, 23, 5);
        pulse(9, 40);
        check("glitch_err_cnt", err_seen, 1);
        check("glitch_code", err_code, ERR_GLITCH);
        check("glitch_state", dbg_state, ST_WAIT_GAP);
        send_bits(24'hA5A5A5, 23, 24);
        send_bits(24'hF00000, 23, 6);
        check("glitch_busy_held", busy, 1);
        gap_and_drain();
        check("glitch_fv", fv_seen, 0);
        check("glitch_keep_frame", frame_data, exp_frame);
        check("glitch_busy_done", busy, 0);
        new_phase();
        expect_pixel(24'h123456, 3'd0);
        send_bits(24'h123456, 23, 24);
        gap_and_drain();
        exp_frame = '0;
        exp_frame[23:0] = 24'h123456;
        check("fresh_fv", fv_seen, 1);
        check("fresh_frame", frame_data, exp_frame);
        check("fresh_err", err_seen, 0);

        // Partial word at latch
        new_phase();
        expect_pixel(24'hC3A5F0, 3'd0);
        send_bits(24'hC3A5F0, 23, 24);
        send_bits(24'hB40000, 23, 6);
        gap_and_drain();
        exp_frame = '0;
        exp_frame[23:0] = 24'hC3A5F0;
        check("part_err_cnt", err_seen, 1);
        check("part_code", last_err, ERR_PARTIAL);
        check("part_fv", fv_seen, 1);
        check("part_pixels", fv_pixels_last, 1);
        check("part_frame", fv_data_last, exp_frame);

        // Overflow: nine pixels into eight slots
        new_phase();
        exp_frame = '0;
        for (int k = 0; k < 9; k++) begin
            w = 24'h010000 | 24'(k + 1);
            expect_pixel(w, (k < 8) ? 3'(k) : 3'd7);
            if (k < 8) exp_frame[k*24 +: 24] = w;
            send_bits(w, 23, 24);
        end
        gap_and_drain();
        check("ovf_err_cnt", err_seen, 1);
        check("ovf_code", err_code, ERR_OVERFLOW);
        check("ovf_fv", fv_seen, 1);
        check("ovf_pixels", frame_pixels, 8);
        check("ovf_frame", frame_data, exp_frame);

        // Reset mid-frame
        new_phase();
        send_bits(24'hFFF000, 23, 12);
        reset = 1'b1;
        #1;
        check("async_rst_frame", frame_data, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_pixels", frame_pixels, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_code", err_code, 0);
        check("mid_rst_state", dbg_state, ST_WAIT_GAP);
        reset = 1'b0;
        repeat (GAP + 100) @(negedge clk);
        new_phase();
        expect_pixel(24'hAABBCC, 3'd0);
        expect_pixel(24'h112233, 3'd1);
        send_bits(24'hAABBCC, 23, 24);
        send_bits(24'h112233, 23, 24);
        gap_and_drain();
        exp_frame = '0;
        exp_frame[23:0]  = 24'hAABBCC;
        exp_frame[47:24] = 24'h112233;
        check("post_rst_fv", fv_seen, 1);
        check("post_rst_pixels", frame_pixels, 2);
        check("post_rst_frame", frame_data, exp_frame);
        check("post_rst_err", err_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
